// File: rtl/quad_pkg.sv
// Shared types and Gray-code helpers for the quadrature encoder bank.
package quad_pkg;

  typedef enum logic [1:0] {QM_X1, QM_X2, QM_X4, QM_RSVD} quad_mode_e;

  typedef struct packed {
    logic valid;
    logic dir;      // 1 = clockwise
    logic illegal;
  } quad_step_t;

  // Position of a {B,A} code along the clockwise cycle 00,01,11,10.
  function automatic logic [1:0] gray_phase(input logic [1:0] g);
    logic [1:0] ph;
    case (g)
      2'b00:   ph = 2'd0;
      2'b01:   ph = 2'd1;
      2'b11:   ph = 2'd2;
      default: ph = 2'd3;
    endcase
    return ph;
  endfunction

  function automatic quad_step_t quad_decode(input logic [1:0] prev, input logic [1:0] cur);
    quad_step_t s;
    logic [1:0] d;
    d         = gray_phase(cur) - gray_phase(prev);
    s.valid   = (d == 2'd1) || (d == 2'd3);
    s.dir     = (d == 2'd1);
    s.illegal = (d == 2'd2);
    return s;
  endfunction

  function automatic logic quad_counts(input quad_mode_e mode, input logic [1:0] cur);
    logic c;
    case (mode)
      QM_X1:   c = (cur == 2'b00);
      QM_X2:   c = (cur == 2'b00) || (cur == 2'b11);
      default: c = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/quad_channel.sv
// One encoder channel: synchroniser, debounce, init handling, Gray decode,
// position counter, step pulses and sticky illegal-transition flag.
module quad_channel
  import quad_pkg::*;
#(
  parameter int POS_W     = 8,
  parameter int DB_CYCLES = 4,
  parameter int SATURATE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       quad_in,
  input  logic [1:0]       mode,
  input  logic             pos_clr,
  input  logic             err_clr,
  output logic [POS_W-1:0] pos,
  output logic             step_cw,
  output logic             step_ccw,
  output logic             err
);

  localparam logic [7:0]       DB_MAX  = 8'(DB_CYCLES);
  localparam logic [POS_W-1:0] POS_MAX = '1;

  logic [1:0]       r_sync1, r_sync2, r_db, r_prev, r_sv;
  logic [7:0]       r_cnt [2];
  logic             r_init, r_step_cw, r_step_ccw, r_err;
  logic [POS_W-1:0] r_pos;

  quad_step_t w_step;
  logic       w_count, w_illegal, w_settled;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_sv    <= '0;
      for (int b = 0; b < 2; b++) r_cnt[b] <= '0;
    end else begin
      // NOTE: non-blocking throughout so every stage samples the previous cycle's value.
      r_sync1 <= quad_in;
      r_sync2 <= r_sync1;
      r_sv    <= {r_sv[0], 1'b1};
      for (int b = 0; b < 2; b++) begin
        if (r_sync2[b] != r_db[b]) begin
          if (r_cnt[b] == DB_MAX) begin
            r_db[b]  <= r_sync2[b];
            r_cnt[b] <= '0;
          end else begin
            r_cnt[b] <= r_cnt[b] + 8'd1;
          end
        end else begin
          r_cnt[b] <= '0;
        end
      end
    end
  end

  // Init ends once the synchroniser holds real samples and the debouncer has caught up.
  assign w_settled = r_sv[1] && (r_sync2 == r_db);

  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output unassigned (no latch).
    w_step    = quad_decode(r_prev, r_db);
    w_count   = 1'b0;
    w_illegal = 1'b0;
    if (!r_init) begin
      w_count   = w_step.valid && quad_counts(quad_mode_e'(mode), r_db);
      w_illegal = w_step.illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev     <= '0;
      r_init     <= 1'b1;
      r_pos      <= '0;
      r_step_cw  <= 1'b0;
      r_step_ccw <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_prev     <= r_db;
      if (r_init && w_settled) r_init <= 1'b0;
      r_step_cw  <= w_count && w_step.dir;
      r_step_ccw <= w_count && !w_step.dir;
      if (pos_clr) begin
        r_pos <= '0;
      end else if (w_count) begin
        if (w_step.dir) begin
          if (!(SATURATE != 0 && r_pos == POS_MAX)) r_pos <= r_pos + 1'b1;
        end else begin
          if (!(SATURATE != 0 && r_pos == '0)) r_pos <= r_pos - 1'b1;
        end
      end
      if (w_illegal)    r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  assign pos      = r_pos;
  assign step_cw  = r_step_cw;
  assign step_ccw = r_step_ccw;
  assign err      = r_err;

endmodule

// File: rtl/quad_encoder_bank.sv
// Multi-channel quadrature decoder: N_CH independent channels sharing one
// resolution mode, outputs packed per channel.
module quad_encoder_bank
  import quad_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int POS_W     = 8,
  parameter int DB_CYCLES = 4,
  parameter int SATURATE  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*N_CH-1:0]     quad_in,
  input  logic [1:0]            mode,
  input  logic [N_CH-1:0]       pos_clr,
  input  logic [N_CH-1:0]       err_clr,
  output logic [N_CH*POS_W-1:0] pos,
  output logic [N_CH-1:0]       step_cw,
  output logic [N_CH-1:0]       step_ccw,
  output logic [N_CH-1:0]       err
);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    quad_channel #(
      .POS_W     (POS_W),
      .DB_CYCLES (DB_CYCLES),
      .SATURATE  (SATURATE)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .quad_in  (quad_in[2*c +: 2]),
      .mode     (mode),
      .pos_clr  (pos_clr[c]),
      .err_clr  (err_clr[c]),
      .pos      (pos[c*POS_W +: POS_W]),
      .step_cw  (step_cw[c]),
      .step_ccw (step_ccw[c]),
      .err      (err[c])
    );
  end

endmodule

// File: tb/tb_quad_encoder_bank.sv
// Bench for quad_encoder_bank: a wrapping and a saturating instance share the
// same pins; a step-level model predicts positions, pulses and error flags.
module tb_quad_encoder_bank;

  localparam int N_CH  = 2;
  localparam int POS_W = 8;
  localparam int DB    = 4;
  localparam int LAT   = DB + 4;  // posedge index after drive at which the pulse is visible

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  quad_in;
  logic [1:0]  mode;
  logic [1:0]  pos_clr, err_clr;
  logic [15:0] pos_w, pos_s;
  logic [1:0]  cw_w, ccw_w, err_w, cw_s, ccw_s, err_s;

  always #5 clk = ~clk;

  quad_encoder_bank #(.N_CH(N_CH), .POS_W(POS_W), .DB_CYCLES(DB), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .quad_in(quad_in), .mode(mode), .pos_clr(pos_clr),
    .err_clr(err_clr), .pos(pos_w), .step_cw(cw_w), .step_ccw(ccw_w), .err(err_w));

  quad_encoder_bank #(.N_CH(N_CH), .POS_W(POS_W), .DB_CYCLES(DB), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .quad_in(quad_in), .mode(mode), .pos_clr(pos_clr),
    .err_clr(err_clr), .pos(pos_s), .step_cw(cw_s), .step_ccw(ccw_s), .err(err_s));

  int   n_cmp = 0;
  int   n_bad = 0;
  logic [1:0] pins [2];
  int   exp_w [2];
  int   exp_s [2];
  logic exp_err [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Index of a {B,A} code walking clockwise 00 -> 01 -> 11 -> 10.
  function automatic int phase(input logic [1:0] g);
    logic [1:0] seq [4];
    seq = '{2'b00, 2'b01, 2'b11, 2'b10};
    for (int i = 0; i < 4; i++) if (seq[i] == g) return i;
    return 0;
  endfunction

  function automatic logic [1:0] code(input int p);
    logic [1:0] seq [4];
    seq = '{2'b00, 2'b01, 2'b11, 2'b10};
    return seq[p % 4];
  endfunction

  task automatic check_state(input string tag);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("%s ch%0d pos_wrap", tag, c), 32'(pos_w[c*8 +: 8]), 32'(exp_w[c]));
      check($sformatf("%s ch%0d pos_sat", tag, c), 32'(pos_s[c*8 +: 8]), 32'(exp_s[c]));
      check($sformatf("%s ch%0d err_wrap", tag, c), 32'(err_w[c]), 32'(exp_err[c]));
      check($sformatf("%s ch%0d err_sat", tag, c), 32'(err_s[c]), 32'(exp_err[c]));
    end
  endtask

  // Move channel ch to code nv and watch 10 cycles. clr_kind: 0 none,
  // 1 pos_clr, 2 err_clr, asserted so it lands on the edge where the step registers.
  task automatic step(input string tag, input int ch, input logic [1:0] nv, input int clr_kind);
    int d, np;
    bit counted, is_cw, illegal;
    int ncw_w [2], nccw_w [2], ncw_s [2], nccw_s [2];
    int first;
    np      = phase(nv);
    d       = (np - phase(pins[ch]) + 4) % 4;
    illegal = (d == 2);
    is_cw   = (d == 1);
    case (mode)
      2'd0:    counted = (d == 1 || d == 3) && (np == 0);
      2'd1:    counted = (d == 1 || d == 3) && (np % 2 == 0);
      default: counted = (d == 1 || d == 3);
    endcase
    first = 0;
    for (int c = 0; c < 2; c++) begin
      ncw_w[c] = 0; nccw_w[c] = 0; ncw_s[c] = 0; nccw_s[c] = 0;
    end
    @(posedge clk); #1;
    quad_in[2*ch +: 2] = nv;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == LAT - 1 && clr_kind == 1) pos_clr[ch] = 1'b1;
      if (k == LAT - 1 && clr_kind == 2) err_clr[ch] = 1'b1;
      if (k == LAT) begin pos_clr = '0; err_clr = '0; end
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        ncw_w[c]  += int'(cw_w[c]);
        nccw_w[c] += int'(ccw_w[c]);
        ncw_s[c]  += int'(cw_s[c]);
        nccw_s[c] += int'(ccw_s[c]);
      end
      if (first == 0 && (cw_w[ch] || ccw_w[ch])) first = k;
    end
    if (counted) begin
      if (is_cw) begin
        exp_w[ch] = (exp_w[ch] + 1) % 256;
        exp_s[ch] = (exp_s[ch] == 255) ? 255 : exp_s[ch] + 1;
      end else begin
        exp_w[ch] = (exp_w[ch] + 255) % 256;
        exp_s[ch] = (exp_s[ch] == 0) ? 0 : exp_s[ch] - 1;
      end
    end
    if (clr_kind == 1) begin exp_w[ch] = 0; exp_s[ch] = 0; end
    if (illegal) exp_err[ch] = 1'b1;
    else if (clr_kind == 2) exp_err[ch] = 1'b0;
    pins[ch] = nv;
    for (int c = 0; c < 2; c++) begin
      check($sformatf("%s ch%0d cw_wrap", tag, c), 32'(ncw_w[c]), 32'(c == ch && counted && is_cw));
      check($sformatf("%s ch%0d ccw_wrap", tag, c), 32'(nccw_w[c]), 32'(c == ch && counted && !is_cw));
      check($sformatf("%s ch%0d cw_sat", tag, c), 32'(ncw_s[c]), 32'(c == ch && counted && is_cw));
      check($sformatf("%s ch%0d ccw_sat", tag, c), 32'(nccw_s[c]), 32'(c == ch && counted && !is_cw));
    end
    if (counted) check($sformatf("%s pulse latency", tag), 32'(first), 32'(LAT));
    check_state(tag);
  endtask

  task automatic pulse_clr(input string tag, input logic [1:0] pmask, input logic [1:0] emask);
    @(posedge clk); #1;
    pos_clr = pmask; err_clr = emask;
    @(posedge clk); #1;
    pos_clr = '0; err_clr = '0;
    for (int c = 0; c < 2; c++) begin
      if (pmask[c]) begin exp_w[c] = 0; exp_s[c] = 0; end
      if (emask[c]) exp_err[c] = 1'b0;
    end
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({tag, " pulses in reset"}, 32'({cw_w, ccw_w, cw_s, ccw_s}), 32'h0);
    for (int c = 0; c < 2; c++) begin exp_w[c] = 0; exp_s[c] = 0; exp_err[c] = 1'b0; end
    check_state({tag, " in reset"});
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check({tag, " pulses after init"}, 32'({cw_w, ccw_w, cw_s, ccw_s}), 32'h0);
    check_state({tag, " after init"});
  endtask

  initial begin
    logic [1:0] g;
    int ch;
    rst = 1'b1; quad_in = 4'b1111; mode = 2'd2; pos_clr = '0; err_clr = '0;
    pins[0] = 2'b11; pins[1] = 2'b11;
    // Pins rest at 11 through reset: init must absorb them without an error.
    do_reset("por");

    for (int i = 0; i < 4; i++) step("x4 cw", 0, code(phase(pins[0]) + 1), 0);
    check("x4 four steps pos0", 32'(pos_w[7:0]), 32'd4);
    check("x4 ch1 untouched", 32'(pos_w[15:8]), 32'd0);

    mode = 2'd0;
    for (int i = 0; i < 4; i++) step("x1 cw", 0, code(phase(pins[0]) + 1), 0);
    check("x1 full cw cycle", 32'(pos_w[7:0]), 32'd5);
    for (int i = 0; i < 4; i++) step("x1 ccw", 0, code(phase(pins[0]) + 3), 0);
    check("x1 full ccw cycle", 32'(pos_w[7:0]), 32'd4);

    mode = 2'd1;
    for (int i = 0; i < 4; i++) step("x2 ccw", 1, code(phase(pins[1]) + 3), 0);

    // Three-cycle glitch on A of channel 0 must be filtered.
    @(posedge clk); #1;
    quad_in[0] = ~quad_in[0];
    repeat (3) @(posedge clk);
    #1 quad_in[0] = ~quad_in[0];
    begin
      int npulse;
      npulse = 0;
      repeat (14) begin
        @(negedge clk);
        npulse += int'(|{cw_w, ccw_w, cw_s, ccw_s});
      end
      check("glitch pulses", 32'(npulse), 32'd0);
      check_state("glitch");
    end

    mode = 2'd2;
    step("illegal", 0, code(phase(pins[0]) + 2), 0);
    check("illegal sets err", 32'(err_w[0]), 32'd1);
    pulse_clr("err_clr alone", 2'b00, 2'b01);
    step("illegal+err_clr", 0, code(phase(pins[0]) + 2), 2);
    check("illegal beats err_clr", 32'(err_w[0]), 32'd1);
    pulse_clr("err_clr again", 2'b00, 2'b01);
    step("pos_clr+step", 1, code(phase(pins[1]) + 1), 1);
    check("pos_clr wins", 32'(pos_w[15:8]), 32'd0);

    for (int i = 0; i < 40; i++) begin
      mode = 2'($urandom_range(0, 3));
      ch   = int'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) g = code(phase(pins[ch]) + 2);
      else if ($urandom_range(0, 1) == 0) g = code(phase(pins[ch]) + 1);
      else g = code(phase(pins[ch]) + 3);
      step($sformatf("rnd%0d", i), ch, g, ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0);
    end

    mode = 2'd2;
    pulse_clr("clear all", 2'b11, 2'b11);
    step("underflow", 0, code(phase(pins[0]) + 3), 0);
    check("wrap 0-1", 32'(pos_w[7:0]), 32'd255);
    check("sat at 0", 32'(pos_s[7:0]), 32'd0);
    for (int i = 0; i < 257; i++) step("climb", 1, code(phase(pins[1]) + 1), 0);
    check("wrap past max", 32'(pos_w[15:8]), 32'd1);
    check("sat at max", 32'(pos_s[15:8]), 32'd255);
    step("overflow", 0, code(phase(pins[0]) + 1), 0);
    check("wrap 255+1", 32'(pos_w[7:0]), 32'd0);

    // Mid-operation reset with arbitrary resting pins.
    do_reset("mid rst");
    step("post rst", 0, code(phase(pins[0]) + 1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/quad_encoder_bank.md
# quad_encoder_bank

Parametrised multi-channel quadrature encoder decoder for front-panel rotary knobs. Each channel synchronises and debounces its A/B pair, decodes Gray-code transitions in a run-time selectable x1/x2/x4 resolution, and keeps a wrapping or saturating position count. The block sits between the board-level encoder pins and the memory-mapped peripheral registers. It also emits per-channel one-cycle step pulses and sticky illegal-transition flags.

## Interface
- N_CH, 2: number of encoder channels (1..8)
- POS_W, 8: position counter width per channel (4..16)
- DB_CYCLES, 4: consecutive stable synchronised samples required before a debounced bit changes (1..255)
- SATURATE, 0: 0 = position wraps modulo 2^POS_W; 1 = position clamps at 0 and 2^POS_W-1

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- quad_in  in  2*N_CH  raw encoder pins; channel c uses bits [2c+1:2c] = {B,A}
- mode  in  2  resolution, common to all channels: 0 = x1, 1 = x2, 2 = x4, 3 = reserved (treated as x4)
- pos_clr  in  N_CH  per-channel position clear
- err_clr  in  N_CH  per-channel error clear
- pos  out  N_CH*POS_W  channel c position at [c*POS_W +: POS_W]
- step_cw  out  N_CH  one-cycle pulse on each counted clockwise step
- step_ccw  out  N_CH  one-cycle pulse on each counted counter-clockwise step
- err  out  N_CH  sticky flag for an illegal transition (both bits changed)

## Operation
- Per bit: 2-flop synchroniser, then debounce counter. The debounced bit takes the synchronised value after DB_CYCLES consecutive cycles in which that value differs from the current debounced value. Any mismatch restarts the count.
- Clockwise Gray sequence is 00→01→11→10→00. Counter-clockwise is the reverse.
- Debounced {B,A} is compared with its previous registered value each cycle:
  - One-bit change: valid step.
  - Two-bit change: illegal. Sets err, no count.
  - No change: idle.
- Counting by mode:
  - x4: every valid step counts.
  - x2: only steps entering 00 or 11 count.
  - x1: only steps entering 00 count (from 10 = cw, from 01 = ccw).
- Counted cw step: pos+1, step_cw=1. Counted ccw step: pos-1, step_ccw=1. step_cw and step_ccw are never high together on one channel.
- Wrap: with SATURATE=0, 2^POS_W-1 +1 gives 0, and 0 −1 gives 2^POS_W-1.
- Saturate: with SATURATE=1, pos holds at the limit. The step pulse still fires.
- pos_clr: pos=0 on the next edge. It wins over a simultaneous step, but that step's pulse still fires.
- err_clr: clears err. A simultaneous illegal transition wins, so err stays 1.
- mode changes apply to the first transition evaluated after the change. No re-alignment is done.
- Reset state: pos=0, step_cw=0, step_ccw=0, err=0, synchroniser and debounce counters cleared, per-channel init flag set.
- While init is set:
  - The first debounced value is loaded as the previous state without counting or flagging.
  - init then clears.
  - This is required so that pins resting at 11 through reset do not raise err.
- Channels are fully independent apart from the shared mode input.

## Timing
- All outputs are registered.
- Input edge sampled at clock edge t, then held stable: debounced bit changes at edge t+2+DB_CYCLES; pos, step pulse and err update at edge t+3+DB_CYCLES.
- Step pulses are exactly one cycle wide.
- Maximum count rate is one counted step per DB_CYCLES+1 cycles per channel.
- rst asserted mid-operation takes effect at the next edge and discards in-flight debounce state. The post-reset init rule then applies.
- pos_clr and err_clr take effect at the next edge; their effect is visible one cycle after assertion.

## Structure
- Package quad_pkg:
  - typedef enum logic [1:0] quad_mode_e {QM_X1, QM_X2, QM_X4, QM_RSVD}.
  - Gray-step decode function returning {valid, dir, illegal} from (prev, cur).
- Sub-module quad_channel: synchroniser, debounce, init flag, decode, counter and flags for one channel.
- The top level generate-instantiates N_CH quad_channel instances and packs their outputs.

## Test plan
- N_CH=2, POS_W=8, DB_CYCLES=4, mode=x4. Ch0 driven through 4 cw steps, each held 10 cycles → pos0 = 4, four step_cw pulses, each 7 cycles after its edge; ch1 pos stays 0.
- Mode x1, full cw cycle 00→01→11→10→00 → pos +1 with one step_cw. Full ccw cycle → pos back to 0.
- SATURATE=0, pos=255, one counted cw step → pos=0. SATURATE=1, same stimulus → pos=255 with step_cw pulsed. pos=0 with a ccw step → pos stays 0.
- Glitch on A of 3 cycles (< DB_CYCLES) → no pos change, no pulse.
- Debounced 00→11 jump → err=1, pos unchanged. err_clr asserted together with another illegal jump → err stays 1.
- Pins held at 11 through rst → after release err=0, pos=0. pos_clr asserted with a simultaneous counted step → pos=0, pulse still seen.
